// File: rtl/line_window_gen_if.sv
// Pixel-in / window-out bundle for the line window generator.
// The slave side is the generator; the master side feeds pixels and takes windows.
interface line_window_gen_if #(
  parameter int K      = 5,
  parameter int DATA_W = 8
);
  logic                             i_valid;
  logic                             i_sof;
  logic [DATA_W-1:0]                pixel_in;
  logic                             o_valid;
  logic                             o_sof;
  logic [K-1:0][K-1:0][DATA_W-1:0]  window;

  modport master (
    output i_valid, i_sof, pixel_in,
    input  o_valid, o_sof, window
  );

  modport slave (
    input  i_valid, i_sof, pixel_in,
    output o_valid, o_sof, window
  );
endinterface

// File: rtl/line_window_gen.sv
// Raster stream to KxK window generator feeding the Gaussian blur stage.
// K-1 one-row line buffers plus a KxK shift window; valid-only windows.
module line_window_gen #(
  parameter int K      = 5,
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  line_window_gen_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_EDGE = CW'(K - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_EDGE = RW'(K - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nx;
  logic [RW-1:0] w_row_nx;
  logic          w_beat;

  logic [DATA_W-1:0] r_lb [K-1][IMG_W];
  logic [DATA_W-1:0] w_rd [K-1];
  logic [K-1:0][DATA_W-1:0] w_cv;

  logic [K-1:0][K-1:0][DATA_W-1:0] r_win;
  logic r_valid;
  logic r_sof;

  assign w_beat = bus.i_valid;

  // Position of the current beat; a start-of-frame beat is always (0,0).
  always_comb begin
    w_col    = r_col;
    w_row    = r_row;
    w_col_nx = r_col;
    w_row_nx = r_row;
    if (bus.i_sof) begin
      w_col = '0;
      w_row = '0;
    end
    if (w_col == C_LAST) begin
      w_col_nx = '0;
      w_row_nx = (w_row == R_LAST) ? '0 : w_row + 1'b1;
    end else begin
      w_col_nx = w_col + 1'b1;
      w_row_nx = w_row;
    end
  end

  // Read the line buffers at the current column and form the column vector.
  always_comb begin
    w_cv = '0;
    for (int j = 0; j < K-1; j++) begin
      w_rd[j] = r_lb[j][w_col];
    end
    w_cv[K-1] = bus.pixel_in;
    for (int k = 0; k < K-1; k++) begin
      w_cv[k] = w_rd[K-2-k];
    end
  end

  // Line buffer cascade: each buffer delays its input by exactly one row.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_lb[0][w_col] <= bus.pixel_in;
      for (int j = 1; j < K-1; j++) begin
        r_lb[j][w_col] <= w_rd[j-1];
      end
    end
  end

  // Counters, window shift and output strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      if (w_beat) begin
        r_col <= w_col_nx;
        r_row <= w_row_nx;
        for (int y = 0; y < K; y++) begin
          for (int x = 0; x < K-1; x++) begin
            r_win[y][x] <= r_win[y][x+1];
          end
          r_win[y][K-1] <= w_cv[y];
        end
        r_valid <= (w_row >= R_EDGE) && (w_col >= C_EDGE);
        r_sof   <= (w_row == R_EDGE) && (w_col == C_EDGE);
      end
    end
  end

  assign bus.o_valid = r_valid;
  assign bus.o_sof   = r_sof;
  assign bus.window  = r_win;

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Streaming window generator that sits directly upstream of the Gaussian blur stage.
- Accepts a raster-order pixel stream, one pixel per accepted beat, and stores K-1 previous image rows in line buffers.
- Presents a registered KxK neighbourhood window with a valid strobe in the exact format the blur stage consumes.
- Emits windows only where the window lies fully inside the image ("valid" convolution), so the output image is (IMG_W-K+1) x (IMG_H-K+1).

Parameters:
K, 5, window size; odd, >=3; must match downstream filter
DATA_W, 8, pixel bit width
IMG_W, 640, active pixels per row; >=K
IMG_H, 480, active rows per frame; >=K

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
i_valid  in  1  pixel_in valid this cycle; no backpressure
i_sof  in  1  start of frame; qualifies the pixel_in beat as pixel (0,0); ignored when i_valid=0
pixel_in  in  DATA_W  raster-order pixel
o_valid  out  1  window valid; feeds filter i_valid
o_sof  out  1  high with the first valid window of a frame
window  out  DATA_W x [K][K]  neighbourhood; [y][x], y=0 top (oldest row), x=0 leftmost (oldest column)

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n).
- Reset: col=0, row=0, o_valid=0, o_sof=0, all window registers=0.
  - Line buffer RAM contents are not reset; valid gating guarantees stale data never appears on o_valid=1.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- Counters:
  - col counts 0..IMG_W-1; row counts 0..IMG_H-1.
  - They advance only on accepted beats (i_valid=1).
  - col wraps to 0 and row increments at col=IMG_W-1.
  - row wraps to 0 after the pixel (IMG_H-1, IMG_W-1).
- i_sof:
  - i_valid=1 and i_sof=1 force the current pixel to (0,0), whatever the counter values.
  - After that beat, col=1 and row=0.
  - The partial old frame is abandoned, with no flush and no output for it.
- Line buffers:
  - K-1 buffers, each depth IMG_W, addressed by col, read-before-write on the same cycle.
  - Column vector on an accepted beat: cv[K-1]=pixel_in; cv[K-2]=LB0[col]; cv[k]=LB(K-2-k)[col].
  - Write on the same beat: LB0[col]<=pixel_in; LBj[col]<=LB(j-1)[col].
  - Each buffer therefore delays its input by exactly one row.
- Window shift:
  - On an accepted beat, window[y][x]<=window[y][x+1] for x<K-1, and window[y][K-1]<=cv[y].
  - With i_valid=0, window holds.
- Output:
  - o_valid<=1 in the cycle after an accepted beat at (r,c) with r>=K-1 and c>=K-1; otherwise 0.
  - Latency is 1 cycle.
  - In that cycle window[K-1][K-1]=pixel(r,c) and window[0][0]=pixel(r-K+1,c-K+1).
  - Windows never straddle a row boundary, because o_valid is gated by c>=K-1.
  - o_sof<=1 only together with o_valid for (r,c)=(K-1,K-1).
- Input gaps of any length are allowed; the output sequence is identical to the gapless case, only spread in time.
- Width rules: col counter is clog2(IMG_W) bits and row counter is clog2(IMG_H) bits; no arithmetic is performed on pixel data.

Test Plan:
Common configuration: K=3, IMG_W=8, IMG_H=6, pixel(r,c)=r*16+c, i_sof on the first beat.
- Gapless full frame -> first o_valid one cycle after pixel (2,2), with window rows {00,01,02},{10,11,12},{20,21,22} and o_sof=1. Exactly 24 o_valid pulses per frame; last window bottom-right=0x57.
- Row wrap -> no o_valid after pixels (3,0) and (3,1). After (3,2), window top-left=0x10 and bottom-right=0x32.
- Random i_valid gaps (~50% duty) -> same 24 windows in the same order. o_valid never high except one cycle after an accepted beat.
- i_sof asserted at pixel (2,5) of frame 1, then a new ramp -> no o_valid until new pixel (2,2). Window there equals the fresh frame values; o_sof=1.
- rst_n low for 2 cycles mid-frame at (4,3) -> o_valid=0, o_sof=0, window=0 while in reset. Restreaming without i_sof gives a first window at (2,2) with correct values.
- Back-to-back frames, two consecutive 48-pixel frames -> 48 windows total. o_sof high exactly twice; frame-2 windows contain no frame-1 data.
